// File: rtl/audio_path_ctrl.sv
// Sample-level sequencer between SPI receiver, effect unit and DAC driver.
// Debounces the mode button, waits on the effect unit with a timeout, and issues one DAC transfer per accepted sample.
module audio_path_ctrl #(
    parameter int CLOCK_MAX   = 25_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int EFF_TIMEOUT = 256
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        sample_valid,
    input  logic [15:0] audio_orig,
    input  logic        eff_done,
    input  logic [15:0] audio_eff,
    input  logic        dac_busy,
    output logic        dac_start,
    output logic [15:0] dac_data,
    output logic        mode_active,
    output logic        timeout_flag,
    output logic [7:0]  drop_count
);
    localparam int DEB_CYC = (CLOCK_MAX / 1000) * DEBOUNCE_MS;
    localparam int DW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int TW      = (EFF_TIMEOUT > 1) ? $clog2(EFF_TIMEOUT) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(EFF_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_EFF = 2'd1,
        WAIT_DAC = 2'd2,
        ISSUE    = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic            btn_meta_r;
    logic            btn_sync_r;
    logic            btn_level_r;
    logic [DW-1:0]   deb_cnt_r;
    logic            mode_req_r;
    logic [15:0]     s_reg_r;
    logic [TW-1:0]   tcnt_r;
    logic            dac_start_r;
    logic [15:0]     dac_data_r;
    logic            mode_active_r;
    logic            timeout_flag_r;
    logic [7:0]      drop_count_r;
    logic            accept_s;
    logic            eff_take_s;
    logic            timeout_s;
    logic            tcnt_inc_s;
    logic            issue_s;
    logic            drop_s;

    // Button synchronizer and debouncer; each accepted press toggles the requested mode.
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            btn_meta_r  <= 1'b0;
            btn_sync_r  <= 1'b0;
            btn_level_r <= 1'b0;
            deb_cnt_r   <= '0;
            mode_req_r  <= 1'b0;
        end else begin
            btn_meta_r <= mode_btn;
            btn_sync_r <= btn_meta_r;
            if (btn_sync_r == btn_level_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_LAST) begin
                deb_cnt_r   <= '0;
                btn_level_r <= btn_sync_r;
                if (btn_sync_r) begin
                    mode_req_r <= ~mode_req_r;
                end
            end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the mode sampled at acceptance picks the path for that sample.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (sample_valid) state_next_s = mode_req_r ? WAIT_EFF : WAIT_DAC;
                else              state_next_s = IDLE;
            end
            WAIT_EFF: begin
                if (eff_done || (tcnt_r == TMO_LAST)) state_next_s = WAIT_DAC;
                else                                  state_next_s = WAIT_EFF;
            end
            WAIT_DAC: begin
                if (!dac_busy) state_next_s = ISSUE;
                else           state_next_s = WAIT_DAC;
            end
            ISSUE:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Per-state control strobes; eff_done wins over timeout in the same cycle.
    always_comb begin
        accept_s   = 1'b0;
        eff_take_s = 1'b0;
        timeout_s  = 1'b0;
        tcnt_inc_s = 1'b0;
        issue_s    = 1'b0;
        case (state_r)
            IDLE: accept_s = sample_valid;
            WAIT_EFF: begin
                if (eff_done)                 eff_take_s = 1'b1;
                else if (tcnt_r == TMO_LAST)  timeout_s  = 1'b1;
                else                          tcnt_inc_s = 1'b1;
            end
            WAIT_DAC: issue_s  = ~dac_busy;
            ISSUE:    issue_s  = 1'b0;
            default:  accept_s = 1'b0;
        endcase
    end

    assign drop_s = sample_valid && (state_r != IDLE);

    // Sample datapath and registered outputs; dac_start/dac_data launch together on entry to ISSUE.
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            s_reg_r        <= 16'h0000;
            tcnt_r         <= '0;
            dac_start_r    <= 1'b0;
            dac_data_r     <= 16'h0000;
            mode_active_r  <= 1'b0;
            timeout_flag_r <= 1'b0;
            drop_count_r   <= 8'd0;
        end else begin
            dac_start_r <= issue_s;
            if (state_r == IDLE) mode_active_r <= mode_req_r;
            if (accept_s) begin
                s_reg_r <= audio_orig;
                tcnt_r  <= '0;
            end else if (eff_take_s) begin
                s_reg_r <= audio_eff;
            end else if (tcnt_inc_s) begin
                tcnt_r <= tcnt_r + TW'(1);
            end
            if (timeout_s) timeout_flag_r <= 1'b1;
            if (issue_s)   dac_data_r     <= s_reg_r;
            if (drop_s && (drop_count_r != 8'hFF)) drop_count_r <= drop_count_r + 8'd1;
        end
    end

    assign dac_start    = dac_start_r;
    assign dac_data     = dac_data_r;
    assign mode_active  = mode_active_r;
    assign timeout_flag = timeout_flag_r;
    assign drop_count   = drop_count_r;

endmodule

// File: tb/tb_audio_path_ctrl.sv
// Scoreboard bench for audio_path_ctrl: stimulus queues expected DAC transfers (data and cycle),
// a monitor pops them on every dac_start; status outputs are checked directly at chosen points.
module tb_audio_path_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mode_btn = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] audio_orig = 16'h0000;
    logic        eff_done = 1'b0;
    logic [15:0] audio_eff = 16'h0000;
    logic        dac_busy = 1'b0;
    logic        dac_start;
    logic [15:0] dac_data;
    logic        mode_active;
    logic        timeout_flag;
    logic [7:0]  drop_count;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_checks = 0;

    audio_path_ctrl #(.CLOCK_MAX(10_000), .DEBOUNCE_MS(1), .EFF_TIMEOUT(256)) dut (
        .clk_25mhz   (clk),
        .reset       (reset),
        .mode_btn    (mode_btn),
        .sample_valid(sample_valid),
        .audio_orig  (audio_orig),
        .eff_done    (eff_done),
        .audio_eff   (audio_eff),
        .dac_busy    (dac_busy),
        .dac_start   (dac_start),
        .dac_data    (dac_data),
        .mode_active (mode_active),
        .timeout_flag(timeout_flag),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Pulse sample_valid for one cycle; lat > 0 queues the expected transfer at cycle + lat.
    task automatic send(input logic [15:0] d, input int lat);
        if (lat > 0) exp_q.push_back('{data: d, cyc: cyc + lat});
        sample_valid = 1'b1;
        audio_orig   = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic press();
        mode_btn = 1'b1;
        tick(12);
        mode_btn = 1'b0;
        tick(20);
    endtask

    // Monitor: every dac_start must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dac_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks = n_checks + 1;
                    $display("FAIL unexpected_dac_start: data %0h at cycle %0d, none expected", dac_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("dac_data_on_start", {16'h0, dac_data}, {16'h0, e.data});
                    chk("dac_start_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r;
        tick(3);
        chk("rst_dac_start", {31'h0, dac_start}, 32'd0);
        chk("rst_dac_data", {16'h0, dac_data}, 32'd0);
        chk("rst_mode_active", {31'h0, mode_active}, 32'd0);
        chk("rst_timeout_flag", {31'h0, timeout_flag}, 32'd0);
        chk("rst_drop_count", {24'h0, drop_count}, 32'd0);
        reset = 1'b1;
        tick(3);

        // Original path, DAC idle: transfer at N+2.
        send(16'h1234, 2);
        tick(5);
        chk("orig_mode_active", {31'h0, mode_active}, 32'd0);
        chk("orig_dac_data_held", {16'h0, dac_data}, 32'h1234);

        // Bouncing button must not toggle the mode.
        for (int i = 0; i < 10; i++) begin
            mode_btn = ~mode_btn;
            tick(4);
        end
        mode_btn = 1'b0;
        tick(20);
        send(16'h5555, 2);
        tick(4);
        chk("bounce_mode_active", {31'h0, mode_active}, 32'd0);

        // Effect path: debounced press selects effect; transfer at M+2 after eff_done.
        press();
        chk("eff_mode_active_before", {31'h0, mode_active}, 32'd1);
        c = cyc;
        send(16'h0100, 0);
        wait_cyc(c + 5);
        eff_done  = 1'b1;
        audio_eff = 16'hABCD;
        exp_q.push_back('{data: 16'hABCD, cyc: cyc + 2});
        tick(1);
        eff_done = 1'b0;
        tick(5);
        chk("eff_dac_data", {16'h0, dac_data}, 32'hABCD);

        // Timeout: 256 WAIT_EFF cycles, flag on the last, transfer two cycles later.
        c = cyc;
        send(16'h7FFF, 258);
        wait_cyc(c + 256);
        chk("timeout_not_yet", {31'h0, timeout_flag}, 32'd0);
        tick(1);
        chk("timeout_set", {31'h0, timeout_flag}, 32'd1);
        tick(4);
        eff_done  = 1'b1;
        audio_eff = 16'hDEAD;
        tick(1);
        eff_done = 1'b0;
        tick(4);
        chk("late_eff_ignored", {16'h0, dac_data}, 32'h7FFF);
        chk("timeout_sticky", {31'h0, timeout_flag}, 32'd1);

        // Backpressure and drops, back to original mode.
        press();
        chk("mode_back_to_orig", {31'h0, mode_active}, 32'd0);
        dac_busy = 1'b1;
        send(16'h1111, 0);
        tick(1);
        send(16'h9001, 0);
        tick(1);
        send(16'h9002, 0);
        tick(1);
        send(16'h9003, 0);
        tick(2);
        chk("drop_count_3", {24'h0, drop_count}, 32'd3);
        r = cyc;
        exp_q.push_back('{data: 16'h1111, cyc: r + 1});
        dac_busy = 1'b0;
        tick(1);
        send(16'h9004, 0);
        tick(2);
        chk("drop_in_issue", {24'h0, drop_count}, 32'd4);
        chk("busy_dac_data", {16'h0, dac_data}, 32'h1111);

        dac_busy     = 1'b1;
        c            = cyc;
        sample_valid = 1'b1;
        audio_orig   = 16'h2222;
        wait_cyc(c + 101);
        chk("drop_count_104", {24'h0, drop_count}, 32'd104);
        wait_cyc(c + 301);
        sample_valid = 1'b0;
        tick(2);
        chk("drop_count_sat", {24'h0, drop_count}, 32'd255);
        r = cyc;
        exp_q.push_back('{data: 16'h2222, cyc: r + 1});
        dac_busy = 1'b0;
        tick(4);
        chk("sat_dac_data", {16'h0, dac_data}, 32'h2222);

        // Reset in WAIT_EFF aborts the sample; late eff_done afterwards is ignored.
        press();
        chk("mode_eff_again", {31'h0, mode_active}, 32'd1);
        send(16'h3333, 0);
        tick(3);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_dac_start", {31'h0, dac_start}, 32'd0);
        chk("async_rst_dac_data", {16'h0, dac_data}, 32'd0);
        chk("async_rst_mode_active", {31'h0, mode_active}, 32'd0);
        chk("async_rst_timeout_flag", {31'h0, timeout_flag}, 32'd0);
        chk("async_rst_drop_count", {24'h0, drop_count}, 32'd0);
        tick(2);
        reset     = 1'b1;
        eff_done  = 1'b1;
        audio_eff = 16'hBEEF;
        tick(1);
        eff_done = 1'b0;
        tick(8);
        chk("post_rst_dac_data", {16'h0, dac_data}, 32'd0);
        chk("post_rst_mode_active", {31'h0, mode_active}, 32'd0);
        send(16'h4444, 2);
        tick(5);
        chk("post_rst_new_sample", {16'h0, dac_data}, 32'h4444);

        tick(5);
        chk("all_transfers_seen", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/audio_path_ctrl.md
Name: audio_path_ctrl

Overview:
Sample-level sequencer for the FPGA audio path. It sits between the SPI receiver, the effect unit and the DAC driver. It debounces the front-panel mode button and selects the original or effect-processed sample, applying mode changes only at sample boundaries. It waits for the effect unit to finish, with a timeout fallback, and issues exactly one DAC transfer per accepted sample. Samples that arrive while a sample is in flight are dropped and counted.

Parameters:
clock_max, 25_000_000, system clock frequency in Hz
debounce_ms, 20, button stable time in ms; DEB_CYC = (clock_max/1000)*debounce_ms
eff_timeout, 256, max cycles to wait for effect completion

Ports:
clk_25mhz  in  1  system clock
reset  in  1  asynchronous reset, active-low
mode_btn  in  1  raw mode button, asynchronous, active-high
sample_valid  in  1  1-cycle pulse: new sample on audio_orig (receiver data_ready)
audio_orig  in  16  original sample from receiver
eff_done  in  1  1-cycle pulse: audio_eff valid (effect process_status)
audio_eff  in  16  effect-processed sample
dac_busy  in  1  DAC driver transfer in progress
dac_start  out  1  1-cycle pulse: start DAC transfer of dac_data
dac_data  out  16  sample to DAC; held between transfers
mode_active  out  1  1 = effect path selected
timeout_flag  out  1  sticky: effect timeout occurred
drop_count  out  8  saturating count of dropped samples

Behaviour:
- Reset (reset=0, async): all outputs 0; FSM=IDLE; sync/debounce regs 0; mode_req=0; counters 0.
- Button: 2-FF synchronizer. Debounce counter reloads on every change of the synced level. The level is accepted once it is stable for DEB_CYC cycles. Each accepted rising level toggles mode_req. Releases toggle nothing.
- mode_active <= mode_req only in IDLE, i.e. at a sample boundary. A sample already in flight keeps the mode latched at its acceptance.
- FSM states: IDLE, WAIT_EFF, WAIT_DAC, ISSUE.
- IDLE: on sample_valid at cycle N, latch audio_orig into s_reg and latch the effective mode (mode_req) into cur_mode. If cur_mode=1, go to WAIT_EFF and clear tcnt; otherwise go to WAIT_DAC.
- WAIT_EFF: if eff_done=1, s_reg<=audio_eff and go to WAIT_DAC. Otherwise tcnt++. When tcnt reaches eff_timeout-1 without eff_done, keep the original sample, set timeout_flag, and go to WAIT_DAC. eff_done in the timeout cycle takes priority, with no flag.
- WAIT_DAC: if dac_busy=0, go to ISSUE; otherwise stay.
- ISSUE: dac_start=1 for exactly one cycle and dac_data<=s_reg in the same cycle. Next state is IDLE.
- Minimum latency, original path, DAC idle: sample_valid at N gives dac_start at N+2. Effect path: eff_done at M gives dac_start at M+2.
- A sample_valid in any state other than IDLE is dropped: drop_count++, saturating at 255, and the state is unaffected. A sample_valid in the same cycle as ISSUE→IDLE is also dropped.
- eff_done outside WAIT_EFF is ignored.
- timeout_flag and drop_count clear only on reset.
- dac_data changes only in ISSUE.
- Reset mid-operation aborts immediately. No dac_start is emitted after reset release until a new sample completes the sequence.

Test Plan:
- Original path: clock_max default, mode 0, audio_orig=16'h1234 with a sample_valid pulse at N, dac_busy=0 → dac_start=1 only at N+2, dac_data=16'h1234 from N+2, mode_active=0.
- Effect path: press the button (sim clock_max=10_000, debounce_ms=1, so DEB_CYC=10), hold 12 cycles, then send a sample 16'h0100. Pulse eff_done with audio_eff=16'hABCD 5 cycles later at M → mode_active=1 before the sample, dac_start at M+2 with dac_data=16'hABCD.
- Bounce rejection: toggle mode_btn every 4 cycles for 40 cycles, then release → mode_req unchanged, mode_active stays 0.
- Timeout: mode 1, sample 16'h7FFF, no eff_done, eff_timeout=256 → timeout_flag=1 after 256 WAIT_EFF cycles; dac_start 2 cycles later with dac_data=16'h7FFF.
- Drop/backpressure: dac_busy=1, accept a sample, then send 3 more sample_valid pulses while in WAIT_DAC → drop_count=3. Release dac_busy → one dac_start carrying the first sample; 300 further drops → drop_count=255.
- Reset mid-operation: assert reset=0 while in WAIT_EFF → all outputs 0 asynchronously. After release, no dac_start until a new sample_valid; a late eff_done is ignored.
